// File: rtl/omsp_spm_key_sequencer.sv
// rtl/omsp_spm_key_sequencer.sv - loads the 128-bit module key into a new SPM, one 16-bit word at a time
// Optional OMSP_SPM_KEY_ZEROIZE_EN: overwrite a partially loaded key with zeros before reporting failure.
module omsp_spm_key_sequencer #(
  parameter int KEY_WORDS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        kdf_start,
  input  logic        kdf_word_valid,
  input  logic [15:0] kdf_word,
  output logic        kdf_word_ready,
  output logic        write_key,
  output logic [15:0] key_in,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int WCW = $clog2(KEY_WORDS + 1);
  localparam logic [WCW-1:0] LAST_CNT  = WCW'(KEY_WORDS);
  localparam logic [15:0]    WAIT_LAST = 16'(TIMEOUT - 1);
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
  localparam int ZCW = $clog2(2 * KEY_WORDS + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE,
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
    S_ZERO,
`endif
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [WCW-1:0]   word_cnt_inc;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [15:0]      key_q, key_d;
  logic             error_q, error_d;
  logic             fail;
  logic [WCW-1:0]   fail_n;
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
  logic [ZCW-1:0]   zero_cnt_q, zero_cnt_d;
`endif

  assign word_cnt_inc = word_cnt_q + WCW'(1);
  assign error        = error_q;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      wait_cnt_q <= '0;
      key_q      <= '0;
      error_q    <= 1'b0;
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
      zero_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      key_q      <= key_d;
      error_q    <= error_d;
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
      zero_cnt_q <= zero_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    key_d          = key_q;
    error_d        = error_q;
    fail           = 1'b0;
    fail_n         = '0;
    kdf_start      = 1'b0;
    kdf_word_ready = 1'b0;
    write_key      = 1'b0;
    key_in         = '0;
    busy           = 1'b1;
    done           = 1'b0;
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
    zero_cnt_d     = zero_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          state_d = S_REQ;
          error_d = 1'b0;
        end
      end
      S_REQ: begin
        kdf_start  = 1'b1;
        wait_cnt_d = '0;
        if (abort) fail = 1'b1;
        else       state_d = S_WAIT;
      end
      S_WAIT: begin
        // A word handed over together with abort is consumed but never written.
        kdf_word_ready = 1'b1;
        if (abort) begin
          fail   = 1'b1;
          fail_n = word_cnt_q;
        end else if (kdf_word_valid) begin
          key_d   = kdf_word;
          state_d = S_WRITE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          fail   = 1'b1;
          fail_n = word_cnt_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_WRITE: begin
        write_key  = 1'b1;
        key_in     = key_q;
        word_cnt_d = word_cnt_inc;
        if (abort) begin
          fail   = 1'b1;
          fail_n = word_cnt_inc;
        end else if (word_cnt_inc == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        word_cnt_d = '0;
        state_d    = S_IDLE;
      end
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
      S_ZERO: begin
        write_key = 1'b1;
        if (zero_cnt_q == ZCW'(1)) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          zero_cnt_d = zero_cnt_q - ZCW'(1);
        end
      end
`endif
      S_ERR: begin
        word_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      word_cnt_d = fail_n;
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
      // Enough zero writes to wrap the SPM word pointer and then cover every word.
      if (fail_n != '0) begin
        state_d    = S_ZERO;
        zero_cnt_d = ZCW'(2 * KEY_WORDS) - ZCW'(fail_n);
      end else begin
        state_d = S_ERR;
        error_d = 1'b1;
      end
`else
      state_d = S_ERR;
      error_d = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_omsp_spm_key_sequencer.sv
// tb/tb_omsp_spm_key_sequencer.sv - randomized and directed bench for omsp_spm_key_sequencer
module tb_omsp_spm_key_sequencer;

  localparam int KW   = 8;
  localparam int TO_A = 4;
  localparam int TO_B = 255;
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  logic        mclk           = 1'b0;
  logic        puc_rst_n      = 1'b0;
  logic        start          = 1'b0;
  logic        abort          = 1'b0;
  logic        kdf_word_valid = 1'b0;
  logic [15:0] kdf_word       = '0;
  logic [1:0]  kdf_start, kdf_word_ready, write_key, busy, done, error;
  logic [15:0] key_in [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  omsp_spm_key_sequencer #(.KEY_WORDS(KW), .TIMEOUT(TO_A)) dut_a (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .start(start), .abort(abort),
    .kdf_start(kdf_start[0]), .kdf_word_valid(kdf_word_valid), .kdf_word(kdf_word),
    .kdf_word_ready(kdf_word_ready[0]), .write_key(write_key[0]), .key_in(key_in[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0])
  );

  omsp_spm_key_sequencer #(.KEY_WORDS(KW), .TIMEOUT(TO_B)) dut_b (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .start(start), .abort(abort),
    .kdf_start(kdf_start[1]), .kdf_word_valid(kdf_word_valid), .kdf_word(kdf_word),
    .kdf_word_ready(kdf_word_ready[1]), .write_key(write_key[1]), .key_in(key_in[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1])
  );

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d cycle=%0d actual=0x%0h required=0x%0h", name, inst, cyc, act, exp);
    end
  endtask

  // Reference model: what each sequencer owes the outside world this cycle.
  int          m_req [2];
  int          m_wait [2];
  int          m_wr [2];
  int          m_words [2];
  int          m_done [2];
  int          m_errp [2];
  int          m_zeros [2];
  int          m_err [2];
  logic [15:0] m_word [2];

  function automatic void m_reset(input int i);
    m_req[i] = 0; m_wait[i] = -1; m_wr[i] = 0; m_words[i] = 0;
    m_done[i] = 0; m_errp[i] = 0; m_zeros[i] = 0; m_err[i] = 0; m_word[i] = '0;
  endfunction

  function automatic void m_fail(input int i);
    m_wait[i] = -1;
    if (ZEROIZE && m_words[i] > 0) m_zeros[i] = 2 * KW - m_words[i];
    else begin
      m_errp[i] = 1;
      m_err[i]  = 1;
    end
    m_words[i] = 0;
  endfunction

  function automatic void m_step(input int i, input int to);
    if (m_req[i] != 0) begin
      m_req[i] = 0;
      if (abort) m_fail(i); else m_wait[i] = 0;
    end else if (m_wait[i] >= 0) begin
      if (abort) m_fail(i);
      else if (kdf_word_valid) begin
        m_word[i] = kdf_word; m_wr[i] = 1; m_wait[i] = -1;
      end else if (m_wait[i] == to - 1) m_fail(i);
      else m_wait[i]++;
    end else if (m_wr[i] != 0) begin
      m_wr[i] = 0;
      m_words[i]++;
      if (abort) m_fail(i);
      else if (m_words[i] == KW) m_done[i] = 1;
      else m_wait[i] = 0;
    end else if (m_done[i] != 0) begin
      m_done[i] = 0; m_words[i] = 0;
    end else if (m_errp[i] != 0) begin
      m_errp[i] = 0; m_words[i] = 0;
    end else if (m_zeros[i] > 0) begin
      m_zeros[i]--;
      if (m_zeros[i] == 0) begin
        m_errp[i] = 1; m_err[i] = 1;
      end
    end else if (start && !abort) begin
      m_req[i] = 1; m_err[i] = 0;
    end
  endfunction

  always @(negedge mclk) begin
    for (int i = 0; i < 2; i++) begin
      if (!puc_rst_n) m_reset(i);
      chk("kdf_start", i, int'(kdf_start[i]), m_req[i]);
      chk("kdf_word_ready", i, int'(kdf_word_ready[i]), int'(m_wait[i] >= 0));
      chk("write_key", i, int'(write_key[i]), int'(m_wr[i] != 0 || m_zeros[i] > 0));
      chk("key_in", i, int'(key_in[i]), (m_wr[i] != 0) ? int'(m_word[i]) : 0);
      chk("busy", i, int'(busy[i]), int'(m_req[i] != 0 || m_wait[i] >= 0 || m_wr[i] != 0 ||
                                          m_done[i] != 0 || m_errp[i] != 0 || m_zeros[i] > 0));
      chk("done", i, int'(done[i]), m_done[i]);
      chk("error", i, int'(error[i]), m_err[i]);
      if (puc_rst_n) m_step(i, (i == 0) ? TO_A : TO_B);
    end
  end

  // Event log used by the hand-computed timing expectations.
  int          wr_cyc_q [$];
  logic [15:0] wr_val_q [$];
  int z0, z1, d0, done0, done1_cyc, busy1_fall, err0_rise, err1_rise, hs;
  logic busy1_prev = 1'b0;
  logic err0_prev  = 1'b0;
  logic err1_prev  = 1'b0;

  always @(negedge mclk) begin
    if (puc_rst_n) begin
      if (write_key[1] && key_in[1] != 16'h0) begin
        wr_cyc_q.push_back(cyc);
        wr_val_q.push_back(key_in[1]);
      end
      if (write_key[1] && key_in[1] == 16'h0) z1++;
      if (write_key[0] && key_in[0] == 16'h0) z0++;
      if (write_key[0] && key_in[0] != 16'h0) d0++;
      if (done[0]) done0++;
      if (done[1] && done1_cyc < 0) done1_cyc = cyc;
      if (busy1_prev && !busy[1] && busy1_fall < 0) busy1_fall = cyc;
      if (!err0_prev && error[0] && err0_rise < 0) err0_rise = cyc;
      if (!err1_prev && error[1] && err1_rise < 0) err1_rise = cyc;
      if (kdf_word_ready[1] && kdf_word_valid) hs++;
    end
    busy1_prev = busy[1];
    err0_prev  = error[0];
    err1_prev  = error[1];
  end

  task automatic clear_logs();
    wr_cyc_q.delete();
    wr_val_q.delete();
    z0 = 0; z1 = 0; d0 = 0; done0 = 0; hs = 0;
    done1_cyc = -1; busy1_fall = -1; err0_rise = -1; err1_rise = -1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge mclk); #1;
      start = 1'b0; abort = 1'b0; kdf_word_valid = 1'b0;
    end
  endtask

  task automatic run_nominal(input bit extra, input bit gap);
    int t;
    int sh;
    clear_logs();
    @(posedge mclk); #1;
    t = cyc; start = 1'b1; abort = 1'b0; kdf_word_valid = 1'b1; kdf_word = 16'h1111;
    for (int n = 0; n < 45; n++) begin
      @(posedge mclk); #1;
      start          = extra && (cyc == t + 5);
      kdf_word_valid = !(gap && cyc >= t + 8 && cyc < t + 18);
      kdf_word       = 16'(16'h1111 * (hs + 1));
    end
    kdf_word_valid = 1'b0;
    sh = gap ? 10 : 0;
    chk("write_count", 1, wr_cyc_q.size(), KW);
    for (int k = 0; k < KW && k < wr_cyc_q.size(); k++) begin
      chk("write_cycle", 1, wr_cyc_q[k] - t, 3 + 2 * k + ((gap && k >= 3) ? 10 : 0));
      chk("write_word", 1, int'(wr_val_q[k]), 16'h1111 * (k + 1));
    end
    chk("done_cycle", 1, done1_cyc - t, 18 + sh);
    chk("busy_low_cycle", 1, busy1_fall - t, 19 + sh);
    chk("error_after_nominal", 1, int'(error[1]), 0);
  endtask

  task automatic run_timeout();
    int t;
    clear_logs();
    @(posedge mclk); #1;
    t = cyc; start = 1'b1; kdf_word_valid = 1'b1; kdf_word = 16'h0A01;
    for (int n = 0; n < 70; n++) begin
      @(posedge mclk); #1;
      start          = 1'b0;
      kdf_word_valid = (cyc < t + 5);
      kdf_word       = 16'(16'h0A01 + hs);
      abort          = (cyc == t + 45);
    end
    abort = 1'b0;
    chk("timeout_data_writes", 0, d0, 2);
    chk("timeout_zero_writes", 0, z0, ZEROIZE ? 14 : 0);
    chk("timeout_error_cycle", 0, err0_rise - t, ZEROIZE ? 24 : 10);
    chk("timeout_done_count", 0, done0, 0);
    chk("timeout_error_flag", 0, int'(error[0]), 1);
    chk("late_abort_zero_writes", 1, z1, ZEROIZE ? 14 : 0);
    chk("late_abort_error_flag", 1, int'(error[1]), 1);
  endtask

  task automatic run_abort();
    int t;
    clear_logs();
    @(posedge mclk); #1;
    t = cyc; start = 1'b1; kdf_word_valid = 1'b1; kdf_word = 16'h2101;
    for (int n = 0; n < 40; n++) begin
      @(posedge mclk); #1;
      start          = 1'b0;
      kdf_word_valid = (cyc < t + 11) || (cyc == t + 12);
      kdf_word       = 16'(16'h2101 + hs);
      abort          = (cyc == t + 12);
    end
    abort = 1'b0; kdf_word_valid = 1'b0;
    chk("abort_data_writes", 1, wr_cyc_q.size(), 5);
    chk("abort_zero_writes", 1, z1, ZEROIZE ? 11 : 0);
    chk("abort_error_cycle", 1, err1_rise - t, ZEROIZE ? 24 : 13);
    chk("abort_done", 1, done1_cyc, -1);
    chk("abort_error_flag", 1, int'(error[1]), 1);
    chk("abort_data_writes", 0, d0, 5);
    chk("abort_zero_writes", 0, z0, ZEROIZE ? 11 : 0);
  endtask

  task automatic run_collision();
    @(posedge mclk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge mclk); #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("collision_kdf_start", i, int'(kdf_start[i]), 0);
      chk("collision_busy", i, int'(busy[i]), 0);
      chk("collision_error_kept", i, int'(error[i]), 1);
    end
  endtask

  task automatic run_reset();
    int t;
    @(posedge mclk); #1;
    t = cyc; start = 1'b1; kdf_word_valid = 1'b1; kdf_word = 16'h3131;
    for (int n = 0; n < 5; n++) begin
      @(posedge mclk); #1;
      start = 1'b0;
    end
    chk("pre_reset_write", 1, int'(write_key[1]), 1);
    #2 puc_rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_kdf_start", i, int'(kdf_start[i]), 0);
      chk("rst_ready", i, int'(kdf_word_ready[i]), 0);
      chk("rst_write_key", i, int'(write_key[i]), 0);
      chk("rst_key_in", i, int'(key_in[i]), 0);
      chk("rst_busy", i, int'(busy[i]), 0);
      chk("rst_done", i, int'(done[i]), 0);
      chk("rst_error", i, int'(error[i]), 0);
    end
    kdf_word_valid = 1'b0;
    @(posedge mclk); #1;
    @(posedge mclk); #1;
    puc_rst_n = 1'b1;
  endtask

  task automatic run_random(input int n_cycles);
    int vmode = 0;
    for (int n = 0; n < n_cycles; n++) begin
      @(posedge mclk); #1;
      if (n % 200 == 0) vmode = $urandom_range(0, 2);
      start = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 59) == 0);
      case (vmode)
        0:       kdf_word_valid = 1'b1;
        1:       kdf_word_valid = ($urandom_range(0, 1) == 1);
        default: kdf_word_valid = ($urandom_range(0, 9) == 0);
      endcase
      kdf_word = 16'($urandom);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_logs();
    repeat (3) @(posedge mclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", i, int'(busy[i]), 0);
      chk("reset_error", i, int'(error[i]), 0);
      chk("reset_key_in", i, int'(key_in[i]), 0);
    end
    puc_rst_n = 1'b1;
    idle(3);
    run_nominal(1'b0, 1'b0); idle(30);
    run_nominal(1'b0, 1'b1); idle(30);
    run_timeout();           idle(30);
    run_abort();             idle(30);
    run_collision();         idle(5);
    run_nominal(1'b1, 1'b0); idle(30);
    run_reset();             idle(5);
    run_nominal(1'b0, 1'b0); idle(30);
    run_random(3000);        idle(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
